pad_reconfig_seq: RTL
=====================

Name: pad_reconfig_seq

Overview:
- Sequences run-time reconfiguration of a single pad's function-select and electrical config (pull/drive bits) for the pad frame.
- Before any function change it forces the pad's output-enable off for a drain window. It then applies the new select and config, holds the gate through a settle window, and releases the gate.
- Sits between the APB pad-control register file (requester) and the pad mux / pad frame. It owns the registered pad_cfg and pad_mux arrays.

Parameters:
- N_IO, 50, number of pads.
- NBIT_PADCFG, 6, config bits per pad; bit 0 = pull enable.
- MUX_W, 2, function-select bits per pad.
- DRAIN_CYC, 4, cycles the output is gated before applying a function change (>=1).
- SETTLE_CYC, 8, cycles the gate is held after applying (>=1).
- IDX_W, $clog2(N_IO), pad index width.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  reconfiguration request valid.
- req_ready_o  out  1  sequencer can accept a request.
- req_pad_i  in  IDX_W  target pad index.
- req_mux_i  in  MUX_W  new function select.
- req_cfg_i  in  NBIT_PADCFG  new pad config.
- done_o  out  1  one-cycle pulse: request completed.
- err_o  out  1  one-cycle pulse: request rejected (index >= N_IO).
- busy_o  out  1  sequence in progress (state != IDLE).
- pad_mux_o  out  N_IO x MUX_W  current function select per pad.
- pad_cfg_o  out  N_IO x NBIT_PADCFG  current config per pad.
- pad_gate_o  out  N_IO  per-pad forced output-disable (1 = OE forced low by pad mux).

Behaviour:
- Reset (async on rst_ni low, regardless of state): state IDLE, counter 0, req_ready_o=1, done_o=0, err_o=0, busy_o=0, pad_gate_o=0, pad_mux_o all 0, pad_cfg_o all 0. Reset mid-sequence aborts with no partial apply beyond what was already registered.
- Handshake: accept on a rising edge with req_valid_i & req_ready_o. req_ready_o=1 only in IDLE. Request fields are latched at accept; later input changes are ignored. valid may drop without acceptance; no ordering obligation on the requester.
- States: IDLE, DRAIN, APPLY, SETTLE, DONE, ERR.
- Classification at accept (cycle 0 = accept edge):
  - Index >= N_IO -> ERR (cycle 1): err_o=1, no register change; IDLE at cycle 2.
  - mux and cfg both equal current values -> DONE at cycle 1 (NOP).
  - mux equal, cfg differs -> APPLY at cycle 1; new cfg visible at cycle 2; DONE at cycle 2; no gating.
  - mux differs -> DRAIN for cycles 1..DRAIN_CYC; APPLY at cycle DRAIN_CYC+1; SETTLE for DRAIN_CYC+2..DRAIN_CYC+SETTLE_CYC+1; DONE at DRAIN_CYC+SETTLE_CYC+2.
- APPLY writes both mux and cfg of the latched pad on its closing edge; other pads are never touched.
- pad_gate_o[idx]=1 exactly in DRAIN, APPLY and SETTLE of a mux-change sequence; 0 in DONE. pad_gate_o is decoded only from registered state and latched index (glitch-free, no input-to-output path).
- done_o=1 only in DONE; err_o=1 only in ERR; never both. State returns to IDLE the cycle after DONE/ERR, so back-to-back requests have a minimum 1-cycle ready gap.
- Counter: down-counter loaded with DRAIN_CYC-1 / SETTLE_CYC-1 on state entry; transition when it reaches 0. No wrap.

Decomposition:
- Package pad_ctrl_pkg holds the state enum, a pad_req_t struct (pad, mux, cfg), and the default DRAIN_CYC/SETTLE_CYC constants.
- One sub-module, pad_seq_timer: loadable down-counter with load value, enable, and a zero flag. The FSM and the cfg/mux register arrays stay in pad_reconfig_seq.

Test Plan:
- Reset release -> pad_mux_o/pad_cfg_o all 0, pad_gate_o=0, req_ready_o=1, busy_o=0.
- Request pad 7, mux 2, cfg 6'h01, accepted at cycle 0 (DRAIN 4, SETTLE 8) -> gate[7]=1 cycles 1..13; mux[7]=2 and cfg[7]=1 visible from cycle 6; done_o at cycle 14 only; ready back at 15.
- Pad 7, same mux 2, cfg 6'h03 -> no gating, cfg[7]=3 at cycle 2, done_o at cycle 2.
- Pad 7, identical mux/cfg -> done_o at cycle 1, outputs unchanged.
- Pad index 55 -> err_o at cycle 1, no done_o, all arrays unchanged, ready at cycle 2.
- rst_ni low at cycle 3 of a mux-change on pad 12 -> immediate gate[12]=0, arrays 0, IDLE; new request after reset completes normally.

Source files
------------

// File: rtl/pad_ctrl_pkg.sv
// Shared types and default timing for the pad reconfiguration sequencer.
package pad_ctrl_pkg;

    localparam int N_IO_DEF        = 50;
    localparam int NBIT_PADCFG_DEF = 6;
    localparam int MUX_W_DEF       = 2;
    localparam int DRAIN_CYC_DEF   = 4;
    localparam int SETTLE_CYC_DEF  = 8;
    localparam int IDX_W_DEF       = $clog2(N_IO_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY,
        ST_SETTLE,
        ST_DONE,
        ST_ERR
    } pad_seq_state_e;

    typedef struct packed {
        logic [IDX_W_DEF-1:0]       pad;
        logic [MUX_W_DEF-1:0]       mux;
        logic [NBIT_PADCFG_DEF-1:0] cfg;
    } pad_req_t;

    // Counter must hold the larger of the two window reload values.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/pad_seq_timer.sv
// Loadable down-counter; holds at zero rather than wrapping.
module pad_seq_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pad_reconfig_seq.sv
// Sequences a single pad's mux/cfg change: gate OE, drain, apply, settle, release.
module pad_reconfig_seq
    import pad_ctrl_pkg::*;
#(
    parameter int N_IO        = N_IO_DEF,
    parameter int NBIT_PADCFG = NBIT_PADCFG_DEF,
    parameter int MUX_W       = MUX_W_DEF,
    parameter int DRAIN_CYC   = DRAIN_CYC_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int IDX_W       = $clog2(N_IO)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [IDX_W-1:0]                    req_pad_i,
    input  logic [MUX_W-1:0]                    req_mux_i,
    input  logic [NBIT_PADCFG-1:0]              req_cfg_i,
    output logic                                done_o,
    output logic                                err_o,
    output logic                                busy_o,
    output logic [N_IO-1:0][MUX_W-1:0]          pad_mux_o,
    output logic [N_IO-1:0][NBIT_PADCFG-1:0]    pad_cfg_o,
    output logic [N_IO-1:0]                     pad_gate_o
);

    localparam int               CNT_W     = cnt_width(DRAIN_CYC, SETTLE_CYC);
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    pad_seq_state_e                  state_q;
    pad_req_t                        req_q;
    logic                            chg_q;
    logic                            done_q;
    logic                            err_q;
    logic [N_IO-1:0][MUX_W-1:0]      pad_mux_q;
    logic [N_IO-1:0][NBIT_PADCFG-1:0] pad_cfg_q;

    logic                            pad_ok;
    logic [MUX_W-1:0]                cur_mux;
    logic [NBIT_PADCFG-1:0]          cur_cfg;
    logic                            mux_diff;
    logic                            cfg_diff;
    logic                            accept;
    logic                            tmr_load;
    logic [CNT_W-1:0]                tmr_load_val;
    logic                            tmr_en;
    logic                            tmr_zero;

    assign pad_ok = ({1'b0, req_pad_i} < (IDX_W+1)'(N_IO));

    // Guard the lookup so an out-of-range index never reads past the array.
    always_comb begin
        cur_mux = '0;
        cur_cfg = '0;
        if (pad_ok) begin
            cur_mux = pad_mux_q[req_pad_i];
            cur_cfg = pad_cfg_q[req_pad_i];
        end
    end

    assign mux_diff = (cur_mux != req_mux_i);
    assign cfg_diff = (cur_cfg != req_cfg_i);
    assign accept   = (state_q == ST_IDLE) && req_valid_i;

    assign tmr_load     = (accept && pad_ok && mux_diff) || ((state_q == ST_APPLY) && chg_q);
    assign tmr_load_val = (state_q == ST_IDLE) ? DRAIN_LD : SETTLE_LD;
    assign tmr_en       = (state_q == ST_DRAIN) || (state_q == ST_SETTLE);

    pad_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            chg_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            pad_mux_q <= '0;
            pad_cfg_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        req_q.pad <= req_pad_i;
                        req_q.mux <= req_mux_i;
                        req_q.cfg <= req_cfg_i;
                        if (!pad_ok) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else if (mux_diff) begin
                            state_q <= ST_DRAIN;
                            chg_q   <= 1'b1;
                        end else if (cfg_diff) begin
                            state_q <= ST_APPLY;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (tmr_zero) state_q <= ST_APPLY;
                end
                ST_APPLY: begin
                    pad_mux_q[req_q.pad] <= req_q.mux;
                    pad_cfg_q[req_q.pad] <= req_q.cfg;
                    if (chg_q) begin
                        state_q <= ST_SETTLE;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        chg_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // chg_q is high only across DRAIN..SETTLE of a mux change, so the gate is fully registered.
    for (genvar i = 0; i < N_IO; i++) begin : g_gate
        assign pad_gate_o[i] = chg_q && (req_q.pad == IDX_W'(i));
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign pad_mux_o   = pad_mux_q;
    assign pad_cfg_o   = pad_cfg_q;

endmodule
